sram_burst_bridge: RTL

//  Byte-stream-to-SRAM bridge, parametrised successor of the single-word UART/SRAM controller.

---
 rtl/sram_bridge_pkg.sv | 23 ++
 rtl/sram_bridge_timeout.sv | 36 +++
 rtl/sram_burst_bridge.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared definitions for the byte-stream-to-SRAM bridge: opcodes, header layout
// and the FSM state encoding.
package sram_bridge_pkg;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;

   localparam int HDR_OP_MSB  = 7;
   localparam int HDR_OP_LSB  = 6;
   localparam int HDR_LEN_MSB = 5;
   localparam int HDR_LEN_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_WRITE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_RD_SEND
   } state_e;

endpackage

// File: rtl/sram_bridge_timeout.sv
// Inter-byte idle counter: expired is asserted on the TIMEOUT_CYC-th consecutive
// enabled cycle without a clear.
module sram_bridge_timeout #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr || !en) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign expired = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sram_burst_bridge.sv
// Parses header/address/data byte packets from the UART receiver and issues
// single or auto-incrementing burst reads and writes to a word-wide SRAM.
module sram_burst_bridge
   import sram_bridge_pkg::*;
#(
   parameter int ADDR_W      = 5,
   parameter int DATA_BYTES  = 4,
   parameter int RD_LAT      = 1,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    rx_ready,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    sram_csb_n,
   output logic                    sram_we_n,
   output logic [ADDR_W-1:0]       sram_addr,
   output logic [8*DATA_BYTES-1:0] sram_wdata,
   input  logic [8*DATA_BYTES-1:0] sram_rdata,
   output logic                    busy,
   output logic                    err
);

   localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
   localparam int DATA_W     = 8 * DATA_BYTES;
   localparam int IDX_W      = 4;
   localparam int LAT_W      = 3;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [5:0]        words_q, words_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              is_read_q, is_read_d;
   logic              tx_valid_q, tx_valid_d;
   logic              rx_ready_q, rx_ready_d;
   logic              err_q, err_d;
   logic              rx_fire, tx_fire, to_en, to_expired;
   logic [DATA_W-1:0] rx_ext;

   // rx_ready and tx_valid are registered, so a transfer is simply valid & ready
   // on the clock edge; neither side may retract valid before the transfer.
   assign rx_fire = rx_valid && rx_ready_q;
   assign tx_fire = tx_valid_q && tx_ready;
   assign to_en   = (state_q == ST_ADDR) || (state_q == ST_WDATA);
   assign rx_ext  = DATA_W'(rx_data) << (DATA_W - 8);

   sram_bridge_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (rx_fire),
      .en      (to_en),
      .expired (to_expired)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      words_d    = words_q;
      idx_d      = idx_q;
      lat_d      = lat_q;
      shreg_d    = shreg_q;
      is_read_d  = is_read_q;
      tx_valid_d = tx_valid_q;
      err_d      = 1'b0;
      case (state_q)
         ST_IDLE: if (rx_fire) begin
            words_d = rx_data[HDR_LEN_MSB:HDR_LEN_LSB];
            idx_d   = '0;
            if (rx_data[HDR_OP_MSB:HDR_OP_LSB] == OP_WRITE) begin
               is_read_d = 1'b0;
               state_d   = ST_ADDR;
            end else if (rx_data[HDR_OP_MSB:HDR_OP_LSB] == OP_READ) begin
               is_read_d = 1'b1;
               state_d   = ST_ADDR;
            end else begin
               err_d = 1'b1;
            end
         end
         // Address arrives MSB first; shifting through ADDR_W bits drops the unused top bits.
         ST_ADDR: if (to_expired) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end else if (rx_fire) begin
            addr_d = ADDR_W'({addr_q, rx_data});
            if (idx_q == IDX_W'(ADDR_BYTES - 1)) begin
               idx_d   = '0;
               state_d = is_read_q ? ST_RD_REQ : ST_WDATA;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_WDATA: if (to_expired) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end else if (rx_fire) begin
            shreg_d = (shreg_q >> 8) | rx_ext;
            if (idx_q == IDX_W'(DATA_BYTES - 1)) begin
               idx_d   = '0;
               state_d = ST_WRITE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_WRITE: begin
            addr_d = addr_q + 1'b1;
            if (words_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               words_d = words_q - 1'b1;
               state_d = ST_WDATA;
            end
         end
         ST_RD_REQ: begin
            lat_d   = '0;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: if (lat_q == LAT_W'(RD_LAT - 1)) begin
            shreg_d    = sram_rdata;
            tx_valid_d = 1'b1;
            idx_d      = '0;
            state_d    = ST_RD_SEND;
         end else begin
            lat_d = lat_q + 1'b1;
         end
         ST_RD_SEND: if (tx_fire) begin
            shreg_d = shreg_q >> 8;
            if (idx_q == IDX_W'(DATA_BYTES - 1)) begin
               tx_valid_d = 1'b0;
               idx_d      = '0;
               addr_d     = addr_q + 1'b1;
               if (words_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  words_d = words_q - 1'b1;
                  state_d = ST_RD_REQ;
               end
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_WDATA);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         words_q    <= '0;
         idx_q      <= '0;
         lat_q      <= '0;
         shreg_q    <= '0;
         is_read_q  <= 1'b0;
         tx_valid_q <= 1'b0;
         rx_ready_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         words_q    <= words_d;
         idx_q      <= idx_d;
         lat_q      <= lat_d;
         shreg_q    <= shreg_d;
         is_read_q  <= is_read_d;
         tx_valid_q <= tx_valid_d;
         rx_ready_q <= rx_ready_d;
         err_q      <= err_d;
      end
   end

   // One shift register serves both directions: write assembly and read serialisation.
   assign rx_ready   = rx_ready_q;
   assign tx_valid   = tx_valid_q;
   assign tx_data    = shreg_q[7:0];
   assign sram_wdata = shreg_q;
   assign sram_addr  = addr_q;
   assign sram_csb_n = !((state_q == ST_WRITE) || (state_q == ST_RD_REQ));
   assign sram_we_n  = (state_q != ST_WRITE);
   assign busy       = (state_q != ST_IDLE);
   assign err        = err_q;

endmodule
